// File: rtl/sample_ext.sv
// Decimating, issue-limited sampler between a free-running producer and a
// valid/ready consumer; reports per-beat freshness and dropped-sample overrun.
module sample_ext #(
    parameter int unsigned      LATENCY    = 0,
    parameter int unsigned      DECIM      = 1,
    parameter int unsigned      MAX_ISSUE  = 0,
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT       = '0,
    parameter bit               INIT_VALID = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             din_valid_i,
    input  logic [WIDTH-1:0] din_data_i,
    output logic             din_ready_o,
    output logic             dout_valid_o,
    output logic [WIDTH-1:0] dout_data_o,
    input  logic             dout_ready_i,
    output logic             fresh_o,
    output logic             overrun_o
);

    localparam int unsigned    DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned    IW    = ($clog2(MAX_ISSUE + 1) > 1) ? $clog2(MAX_ISSUE + 1) : 1;
    localparam logic [DW-1:0]  DLAST = DW'(DECIM - 1);
    localparam logic [IW-1:0]  IEXP  = IW'(MAX_ISSUE);
    localparam logic [IW-1:0]  ISAT  = '1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [IW-1:0]    icnt_q, icnt_d;
    logic             lock_q, lock_d;
    logic             overrun_q, overrun_d;

    logic qual, capture, hs;

    assign din_ready_o = 1'b1;
    assign overrun_o   = overrun_q;
    assign qual        = din_valid_i && (dcnt_q == '0);
    assign capture     = qual && !lock_q;

    always_comb begin
        if (LATENCY == 0 && capture) begin
            dout_data_o  = din_data_i;
            dout_valid_o = 1'b1;
            fresh_o      = 1'b1;
        end else begin
            dout_data_o  = data_q;
            dout_valid_o = valid_q;
            fresh_o      = (icnt_q == '0);
        end
    end

    assign hs = dout_valid_o && dout_ready_i;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        dcnt_d    = dcnt_q;
        icnt_d    = icnt_q;
        lock_d    = dout_valid_o && !dout_ready_i;
        overrun_d = qual && lock_q;

        if (din_valid_i)
            dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;

        // In bypass mode the handshake belongs to the new beat; registered mode
        // spends it on the outgoing sample, so the fresh one starts at zero.
        if (capture) begin
            data_d  = din_data_i;
            icnt_d  = (LATENCY == 0 && hs) ? IW'(1) : '0;
            valid_d = !(MAX_ISSUE != 0 && icnt_d == IEXP);
        end else if (hs) begin
            icnt_d = (icnt_q == ISAT) ? icnt_q : icnt_q + 1'b1;
            if (MAX_ISSUE != 0 && icnt_d == IEXP)
                valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= INIT_VALID ? INIT : '0;
            valid_q   <= INIT_VALID;
            dcnt_q    <= '0;
            icnt_q    <= '0;
            lock_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            dcnt_q    <= dcnt_d;
            icnt_q    <= icnt_d;
            lock_q    <= lock_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: doc/sample_ext.md
# sample_ext

Parametrised successor to the single-register sampler. It sits between a free-running producer and a dti consumer and always accepts input. It presents the most recent qualifying sample to the consumer and adds three things: input decimation, a bounded re-issue count for held samples, and freshness/overrun status. A qualifying sample is every DECIM-th valid input beat.

## Interface
Parameters:
- LATENCY, 0: 0 = combinational bypass of a qualifying input; 1 = output always from register.
- DECIM, 1: forward one of every DECIM valid input beats (≥1).
- MAX_ISSUE, 0: handshakes allowed per sample. 0 = unlimited (hold forever); 1 = no hold.
- INIT, 0: register value after reset when INIT_VALID=1.
- INIT_VALID, 0: dout.valid after reset.

Ports (W = $size(din.data)):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  dti.consumer  W  sample input; din.ready tied 1.
- dout  dti.producer  W  sampled output.
- fresh  out  1  current dout beat is the first issue of its sample.
- overrun  out  1  registered one-cycle pulse: a qualifying sample was dropped.

## Operation
- State:
  - S: data register, W bits.
  - SV: valid flag.
  - dcnt: decimation counter, 0..DECIM-1.
  - icnt: issue counter, $clog2(MAX_ISSUE+1) bits, minimum 1.
  - lock: dout was valid and not handshaken in the previous cycle.
- Reset (rst=0, async):
  - S = INIT_VALID ? INIT : 0; SV = INIT_VALID.
  - dcnt = 0, icnt = 0, lock = 0, overrun = 0.
- Qualify: q = din.valid && dcnt==0.
  - dcnt advances on every din.valid, qualifying or not, and wraps at DECIM-1.
  - DECIM=1 makes every valid beat qualify.
- Capture:
  - Condition: q && !lock. Then S←din.data, SV←1.
  - icnt←1 if the beat is handshaken in the same cycle, else 0.
  - q && lock: sample dropped, overrun←1 next cycle, S untouched.
- Handshake on a held sample (no capture): icnt←icnt+1, saturating.
  - If MAX_ISSUE≠0 and the new icnt == MAX_ISSUE: SV←0.
- lock ← dout.valid && !dout.ready.
- Output, LATENCY=0:
  - If q && !lock: dout.data=din.data, dout.valid=1, fresh=1.
  - Otherwise: dout.data=S, dout.valid=SV, fresh=(icnt==0).
- Output, LATENCY=1: dout.data=S, dout.valid=SV, fresh=(icnt==0), in every cycle.
- Dti rule: once dout.valid rises, dout.data and dout.valid stay constant until dout.ready. lock enforces this; a held sample never expires while stalled.
- INIT sample after reset has icnt=0, so it counts as fresh.

## Timing
- Latency, din to dout:
  - LATENCY=0: 0 cycles when unlocked.
  - LATENCY=1: 1 cycle.
  - Either mode: 1 cycle after the lock clears.
- Throughput: one sample per cycle, with ready=1 and DECIM=1.
- Simultaneous capture and handshake on the old sample (LATENCY=1): the capture wins, the new sample is loaded, icnt=0. The old sample's issue is counted, no overrun.
- Expiry with MAX_ISSUE=N: dout.valid falls in the cycle after the N-th handshake, unless a capture occurs in that same cycle.
- dcnt wrap: with DECIM=3, beats 0,3,6… qualify, regardless of gaps in din.valid.
- Reset mid-stall: all state clears immediately. dout.valid follows INIT_VALID asynchronously and the lock is released.
- overrun is asserted exactly one cycle per dropped sample. Back-to-back drops keep it high.

## Test plan
- Reset, INIT_VALID=1, INIT=0x5A, LATENCY=1, ready=1, no input -> dout=0x5A valid every cycle; fresh=1 on the first cycle only; overrun=0.
- LATENCY=0, DECIM=1, MAX_ISSUE=1, ready=1, din 0x01,0x02,0x03 back-to-back -> dout shows 0x01,0x02,0x03 in the same cycles with fresh=1; dout.valid=0 in the following cycle.
- DECIM=3, din valid with values 10..17 every cycle, LATENCY=1 -> dout carries 10, 13, 16, each one cycle later; intermediate beats never appear.
- MAX_ISSUE=2, one input 0x7 then idle, ready=1 -> 0x7 handshaken exactly twice (fresh=1 then 0); valid falls on the next cycle.
- ready=0 while holding 0x4, din 0x8 qualifying during the stall -> dout stays 0x4; overrun pulses once; on ready=1, 0x4 completes and 0x8 is not presented.
- rst asserted during a stall with dout valid -> dout.valid drops (INIT_VALID=0) without a clock edge; after release, the next input 0x9 appears with fresh=1.
